// File: rtl/wavelet_pkg.sv
// wavelet_pkg: constants and FSM encoding shared by the tap line and the tap MAC reader.
//   TOTAL_TAPS / BITS_PER_TAP / COEF_BITS : default packing of taps and coefficients
//   ACC_BITS : accumulator width (product width plus growth for TOTAL_TAPS additions)
//   mac_state_t : IDLE=0, RUN=1, DONE=2
package wavelet_pkg;
  localparam int TOTAL_TAPS = 9;
  localparam int BITS_PER_TAP = 8;
  localparam int COEF_BITS = 8;
  function automatic int acc_bits(input int taps, input int tap_bits, input int coef_bits);
    return tap_bits + coef_bits + $clog2(taps);
  endfunction
  localparam int ACC_BITS = acc_bits(TOTAL_TAPS, BITS_PER_TAP, COEF_BITS);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} mac_state_t;
endpackage

// File: rtl/tap_mac_reader_if.sv
// tap_mac_reader_if: start/tap/coefficient request plus valid/ready result bundle.
//   master : drives i_start, i_taps, i_coeffs, i_ready; observes o_busy, o_valid, o_result
//   slave  : the reader side of the same signals
interface tap_mac_reader_if
  import wavelet_pkg::*;
#(
  parameter int TOTAL_TAPS = wavelet_pkg::TOTAL_TAPS,
  parameter int BITS_PER_TAP = wavelet_pkg::BITS_PER_TAP,
  parameter int COEF_BITS = wavelet_pkg::COEF_BITS,
  parameter int ACC_BITS = wavelet_pkg::ACC_BITS
);
  logic i_start;
  logic [TOTAL_TAPS*BITS_PER_TAP-1:0] i_taps;
  logic [TOTAL_TAPS*COEF_BITS-1:0] i_coeffs;
  logic i_ready;
  logic o_busy;
  logic o_valid;
  logic [ACC_BITS-1:0] o_result;
  modport master (output i_start, i_taps, i_coeffs, i_ready, input o_busy, o_valid, o_result);
  modport slave (input i_start, i_taps, i_coeffs, i_ready, output o_busy, o_valid, o_result);
endinterface

// File: rtl/tap_mac_reader_signed_mac.sv
// signed_mac: combinational signed multiply with sign-extended accumulate.
//   acc_in  : running sum
//   a, b    : signed operands
//   acc_out : acc_in + sign-extended a*b, wrapping at ACC_BITS
module signed_mac #(
  parameter int A_BITS = 8,
  parameter int B_BITS = 8,
  parameter int ACC_BITS = 20
) (
  input  logic signed [ACC_BITS-1:0] acc_in,
  input  logic signed [A_BITS-1:0]   a,
  input  logic signed [B_BITS-1:0]   b,
  output logic signed [ACC_BITS-1:0] acc_out
);
  logic signed [A_BITS+B_BITS-1:0] p;
  assign p = a * b;
  assign acc_out = acc_in + ACC_BITS'(p);
endmodule

// File: rtl/tap_mac_reader.sv
// tap_mac_reader: snapshots a packed tap/coefficient set on start and reduces it to one signed sum,
// one multiply-accumulate per clock, returned over a valid/ready handshake.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : request (i_start, i_taps, i_coeffs), result (o_valid, o_result, i_ready), o_busy
module tap_mac_reader
  import wavelet_pkg::*;
#(
  parameter int TOTAL_TAPS = wavelet_pkg::TOTAL_TAPS,
  parameter int BITS_PER_TAP = wavelet_pkg::BITS_PER_TAP,
  parameter int TOTAL_BITS = TOTAL_TAPS * BITS_PER_TAP,
  parameter int COEF_BITS = wavelet_pkg::COEF_BITS,
  parameter int ACC_BITS = acc_bits(TOTAL_TAPS, BITS_PER_TAP, COEF_BITS)
) (
  input logic clk,
  input logic reset,
  tap_mac_reader_if.slave bus
);
  localparam int IDX_W = TOTAL_TAPS > 1 ? $clog2(TOTAL_TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TOTAL_TAPS - 1);
  mac_state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d, mac_out;
  logic [TOTAL_BITS-1:0] taps_q, taps_d;
  logic [TOTAL_TAPS*COEF_BITS-1:0] coeffs_q, coeffs_d;
  logic [ACC_BITS-1:0] result_q, result_d;
  logic valid_q, valid_d, busy_q, busy_d;
  logic signed [BITS_PER_TAP-1:0] tap;
  logic signed [COEF_BITS-1:0] coef;
  logic load;
  assign tap = taps_q[idx_q*BITS_PER_TAP +: BITS_PER_TAP];
  assign coef = coeffs_q[idx_q*COEF_BITS +: COEF_BITS];
  signed_mac #(.A_BITS(BITS_PER_TAP), .B_BITS(COEF_BITS), .ACC_BITS(ACC_BITS)) u_mac (
    .acc_in(acc_q), .a(tap), .b(coef), .acc_out(mac_out)
  );
  // a start is taken from IDLE, or from DONE only on the handshake edge (back-to-back)
  assign load = bus.i_start && (state_q == IDLE || (state_q == DONE && bus.i_ready));
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    taps_d = taps_q;
    coeffs_d = coeffs_q;
    result_d = result_q;
    valid_d = valid_q;
    case (state_q)
      RUN: begin
        acc_d = mac_out;
        idx_d = idx_q == LAST ? '0 : idx_q + 1'b1;
        if (idx_q == LAST) begin
          result_d = mac_out;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: ;
    endcase
    if (load) begin
      taps_d = bus.i_taps;
      coeffs_d = bus.i_coeffs;
      acc_d = '0;
      idx_d = '0;
      state_d = RUN;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      taps_q <= '0;
      coeffs_q <= '0;
      result_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      taps_q <= taps_d;
      coeffs_q <= coeffs_d;
      result_q <= result_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign bus.o_busy = busy_q;
  assign bus.o_valid = valid_q;
  assign bus.o_result = result_q;
endmodule

// File: tb/tb_tap_mac_reader.sv
// tb_tap_mac_reader: directed checks of the tap MAC reader with hand-computed sums.
module tb_tap_mac_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  int n;
  logic [71:0] tv;
  logic [71:0] cv;
  tap_mac_reader_if bus ();
  tap_mac_reader u_dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!bus.o_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask
  function automatic logic [71:0] fill(input logic [7:0] v);
    return {9{v}};
  endfunction
  task automatic start_pulse();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_taps = '0;
    bus.i_coeffs = '0;
    tick();
    tick();
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_result", 32'(bus.o_result), 32'd0);
    reset = 1'b0;
    tick();
    // all ones
    bus.i_taps = fill(8'd1);
    bus.i_coeffs = fill(8'd1);
    start_pulse();
    chk("ones_busy_e0", 32'(bus.o_busy), 32'd1);
    chk("ones_valid_e0", 32'(bus.o_valid), 32'd0);
    wait_valid(n);
    chk("ones_latency", 32'(n), 32'd9);
    chk("ones_result", 32'(bus.o_result), 32'd9);
    tick();
    chk("ones_valid_after", 32'(bus.o_valid), 32'd0);
    chk("ones_busy_after", 32'(bus.o_busy), 32'd0);
    chk("ones_result_held", 32'(bus.o_result), 32'd9);
    // extreme negative operands: 9 * 16384
    bus.i_taps = fill(8'h80);
    bus.i_coeffs = fill(8'h80);
    start_pulse();
    wait_valid(n);
    chk("neg_latency", 32'(n), 32'd9);
    chk("neg_result", 32'(bus.o_result), 32'h24000);
    tick();
    // ordering: tap k = k
    for (int k = 0; k < 9; k++) tv[k*8 +: 8] = 8'(k);
    bus.i_taps = tv;
    bus.i_coeffs = 72'd1 << 24;
    start_pulse();
    wait_valid(n);
    chk("order_c3", 32'(bus.o_result), 32'd3);
    tick();
    bus.i_coeffs = 72'hFF << 64;
    start_pulse();
    wait_valid(n);
    chk("order_c8", 32'(bus.o_result), 32'hFFFF8);
    tick();
    // backpressure: 2*3*9 = 54
    bus.i_ready = 1'b0;
    bus.i_taps = fill(8'd2);
    bus.i_coeffs = fill(8'd3);
    start_pulse();
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'd9);
    for (int i = 0; i < 5; i++) begin
      bus.i_start = ~bus.i_start;
      bus.i_taps = fill(8'(i + 7));
      bus.i_coeffs = fill(8'(i + 11));
      tick();
      chk("bp_valid_hold", 32'(bus.o_valid), 32'd1);
      chk("bp_result_hold", 32'(bus.o_result), 32'd54);
    end
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    chk("bp_valid_done", 32'(bus.o_valid), 32'd0);
    chk("bp_busy_done", 32'(bus.o_busy), 32'd0);
    tick();
    chk("bp_no_queue", 32'(bus.o_busy), 32'd0);
    // back-to-back: A = 1*2*9 = 18, B = 3*(-1)*9 = -27
    bus.i_taps = fill(8'd1);
    bus.i_coeffs = fill(8'd2);
    bus.i_start = 1'b1;
    tick();
    bus.i_taps = fill(8'd3);
    bus.i_coeffs = fill(8'hFF);
    wait_valid(n);
    chk("b2b_a_latency", 32'(n), 32'd9);
    chk("b2b_a_result", 32'(bus.o_result), 32'd18);
    tick();
    bus.i_taps = fill(8'hFE);
    bus.i_coeffs = fill(8'd5);
    chk("b2b_valid_drop", 32'(bus.o_valid), 32'd0);
    chk("b2b_busy_kept", 32'(bus.o_busy), 32'd1);
    wait_valid(n);
    chk("b2b_b_latency", 32'(n), 32'd9);
    chk("b2b_b_result", 32'(bus.o_result), 32'hFFFE5);
    bus.i_start = 1'b0;
    tick();
    chk("b2b_idle", 32'(bus.o_busy), 32'd0);
    // reset on the 4th RUN cycle, then fresh run: sum k = 36
    bus.i_taps = fill(8'd1);
    bus.i_coeffs = fill(8'd1);
    start_pulse();
    tick();
    tick();
    tick();
    chk("rr_busy_mid", 32'(bus.o_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rr_busy", 32'(bus.o_busy), 32'd0);
    chk("rr_valid", 32'(bus.o_valid), 32'd0);
    chk("rr_result", 32'(bus.o_result), 32'd0);
    bus.i_taps = tv;
    start_pulse();
    wait_valid(n);
    chk("rr_latency", 32'(n), 32'd9);
    chk("rr_result_fresh", 32'(bus.o_result), 32'd36);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
